blackparrot_fpga_host_cmd_arbiter: RTL and testbench
====================================================

Name: blackparrot_fpga_host_cmd_arbiter

Overview:
Shares the single FIFO-style command port of the host's fifo-to-AXI bridge between num_req_p requesters, for example the NBF loader and a host debug/MMIO requester. Commands are single-beat reads or writes, granted round-robin. Each granted requester's index is recorded in a per-type tag FIFO (write or read), so the bridge's B and R responses route back to the correct requester. This holds even when writes and reads complete out of order relative to each other. The block sits between the requesters and the bridge inside the host top level.

Parameters:
num_req_p, 2, number of requesters (>=2)
addr_width_p, 64, command address width
data_width_p, 64, command/response data width
tag_els_p, 8, max outstanding writes and, separately, max outstanding reads (depth of each tag FIFO)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_v_i  in  num_req_p  per-requester command valid
req_w_i  in  num_req_p  1=write, 0=read
req_addr_i  in  num_req_p*addr_width_p  packed addresses, requester 0 in LSBs
req_data_i  in  num_req_p*data_width_p  packed write data
req_wmask_i  in  num_req_p*(data_width_p/8)  packed byte masks
req_size_i  in  num_req_p*3  packed log2 byte size
req_ready_and_o  out  num_req_p  command accepted when req_v_i & req_ready_and_o
resp_v_o  out  num_req_p  response valid, at most one bit set
resp_w_o  out  1  response is write ack
resp_data_o  out  data_width_p  read data, shared by all requesters
resp_yumi_i  in  num_req_p  response consumed
cmd_v_o  out  1  to bridge
cmd_w_o  out  1  to bridge
cmd_addr_o  out  addr_width_p  to bridge
cmd_data_o  out  data_width_p  to bridge
cmd_wmask_o  out  data_width_p/8  to bridge
cmd_size_o  out  3  to bridge
cmd_ready_and_i  in  1  from bridge
br_resp_v_i  in  1  from bridge
br_resp_w_i  in  1  from bridge
br_resp_data_i  in  data_width_p  from bridge
br_resp_yumi_o  out  1  to bridge
wr_outstanding_o  out  clog2(tag_els_p+1)  writes in flight
rd_outstanding_o  out  clog2(tag_els_p+1)  reads in flight
idle_o  out  1  no reads or writes in flight (used for fence/finish)

Behaviour:
- Eligibility: requester i is eligible when req_v_i[i] is set and the tag FIFO selected by req_w_i[i] is not full. A full FIFO blocks pushes even if a pop occurs in the same cycle.
- Arbitration is round-robin over eligible requesters, starting at the pointer. cmd_v_o = any eligible requester; cmd_* = winner's fields, fully combinational with zero added latency.
- req_ready_and_o[i] = (i is the winner) & cmd_ready_and_i. Handshake only when cmd_v_o & cmd_ready_and_i.
- On handshake:
  - push winner index into the write tag FIFO if cmd_w_o, else into the read tag FIFO;
  - pointer <= (winner+1) mod num_req_p.
- With no handshake, the pointer holds. The winner may change while cmd_ready_and_i is low; the bridge must not depend on a stable cmd_* before acceptance.
- Response routing: br_resp_w_i selects the write or read tag FIFO. If that FIFO is non-empty:
  - resp_v_o[head] = br_resp_v_i;
  - br_resp_yumi_o = resp_yumi_i[head];
  - pop the FIFO on br_resp_yumi_o.
- resp_w_o and resp_data_o pass through from the bridge.
- Spurious response (selected FIFO empty): drop it with br_resp_yumi_o=1, all resp_v_o=0. A simulation assertion fires.
- Responses to one requester arrive in that requester's issue order within each type. Write-vs-read order is not preserved.
- A command accept and a response pop may occur in the same cycle. The counters net out: +1 and -1 on the same type means no change.
- Counters equal the tag FIFO occupancies. idle_o = both FIFOs empty.
- Reset values:
  - FIFOs empty, pointer=0, counters=0, idle_o=1;
  - cmd_v_o=0, all resp_v_o=0, all req_ready_and_o=0.
- Reset mid-operation discards all tags. Bridge responses to pre-reset commands are then treated as spurious; the bridge is reset by the same reset.
- Requesters must hold their command stable until accepted (ready_and protocol).

Decomposition:
- Shared package (blackparrot_fpga_host_pkg): command struct {w, addr, data, wmask, size} and the size encodings e_size_4B=3'b010, e_size_8B=3'b011.
- Tag FIFOs: two instances of bsg_fifo_1r1w_small, width clog2(num_req_p), els tag_els_p.
- Sub-module: bsg_arb_round_robin for the grant logic.
- Routing and counters live in the top module.

Test Plan:
- Single read from req 1, addr 0x8000_0000: bridge returns data 0xDEADBEEF_CAFEF00D -> resp_v_o=2'b10, resp_w_o=0, data matches, rd_outstanding returns 1 then 0.
- Both requesters hold write valid, cmd_ready_and_i=1 for 6 cycles -> grants alternate 0,1,0,1,0,1; 3 write acks routed to each requester in order.
- tag_els_p=2, req 0 issues 3 reads with no responses -> third stalls (req_ready_and_o[0]=0) while req 0 write is still accepted; releasing one read response unblocks it the next cycle.
- Req 0 write to 0x100 and req 1 read in flight; bridge returns read response first, then B -> read routed to req 1, ack to req 0, idle_o=1 only after both are consumed.
- Hold resp_yumi_i=0 for 4 cycles -> br_resp_yumi_o=0, resp_v_o stays asserted, FIFO not popped; spurious write ack with empty write FIFO -> dropped, assertion fires.
- Assert reset with 2 reads outstanding -> counters=0, idle_o=1, pointer=0; next grant goes to req 0 when both requesters are valid.

Source files
------------

// File: rtl/blackparrot_fpga_host_pkg.sv
`default_nettype none
// ============================================================================
// Package  : blackparrot_fpga_host_pkg
// Brief    : Shared host-side command type and transfer size encodings.
// Revision : 1.0
// ============================================================================
package blackparrot_fpga_host_pkg;

    localparam int c_host_addr_width = 64;
    localparam int c_host_data_width = 64;
    localparam int c_host_mask_width = c_host_data_width / 8;

    typedef enum logic [2:0] {
        e_size_1B = 3'b000,
        e_size_2B = 3'b001,
        e_size_4B = 3'b010,
        e_size_8B = 3'b011
    } host_size_e;

    typedef struct packed {
        logic                          w;
        logic [c_host_addr_width-1:0]  addr;
        logic [c_host_data_width-1:0]  data;
        logic [c_host_mask_width-1:0]  wmask;
        logic [2:0]                    size;
    } host_cmd_s;

endpackage
`default_nettype wire

// File: rtl/bsg_arb_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : bsg_arb_round_robin
// Brief    : Round-robin grant; pointer moves past the winner on yumi_i.
// Revision : 1.0
// ============================================================================
module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [width_p-1:0]                              reqs_i,
    input  logic                                            yumi_i,
    output logic                                            v_o,
    output logic [width_p-1:0]                              grants_o,
    output logic [((width_p > 1) ? $clog2(width_p) : 1)-1:0] tag_o
);

    localparam int c_idx_width   = (width_p > 1) ? $clog2(width_p) : 1;
    localparam int c_probe_width = c_idx_width + 1;

    logic [c_idx_width-1:0]   r_ptr;
    logic [c_idx_width-1:0]   w_idx;
    logic [c_probe_width-1:0] w_probe;
    logic                     w_found;

    // Scan from the pointer upward, wrapping once; first requester seen wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_probe = '0;
        for (int k = 0; k < width_p; k++) begin
            w_probe = {1'b0, r_ptr} + c_probe_width'(k);
            if (w_probe >= c_probe_width'(width_p)) begin
                w_probe = w_probe - c_probe_width'(width_p);
            end
            if (!w_found && reqs_i[w_probe[c_idx_width-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_probe[c_idx_width-1:0];
            end
        end
    end

    always_comb begin
        grants_o        = '0;
        grants_o[w_idx] = w_found;
    end

    assign v_o   = w_found;
    assign tag_o = w_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (yumi_i & w_found) begin
            r_ptr <= (w_idx == c_idx_width'(width_p - 1)) ? '0 : w_idx + c_idx_width'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_1r1w_small
// Brief    : Small circular-buffer FIFO, valid/ready in, valid/yumi out.
// Revision : 1.0
// ============================================================================
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int c_ptr_width = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int c_cnt_width = $clog2(els_p + 1);

    logic [width_p-1:0]     r_mem [els_p];
    logic [c_ptr_width-1:0] r_wptr;
    logic [c_ptr_width-1:0] r_rptr;
    logic [c_cnt_width-1:0] r_cnt;
    logic                   w_push;
    logic                   w_pop;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even when the head is being popped in the same cycle.
    assign ready_o = (r_cnt != c_cnt_width'(els_p));
    assign v_o     = (r_cnt != '0);
    assign data_o  = r_mem[r_rptr];
    assign w_push  = v_i & ready_o;
    assign w_pop   = yumi_i & v_o;

    function automatic logic [c_ptr_width-1:0] next_ptr(input logic [c_ptr_width-1:0] p);
        return (p == c_ptr_width'(els_p - 1)) ? '0 : p + c_ptr_width'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            r_cnt <= r_cnt + c_cnt_width'(w_push) - c_cnt_width'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/blackparrot_fpga_host_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : blackparrot_fpga_host_cmd_arbiter
// Brief    : Shares the bridge command port round-robin; per-type tag FIFOs
//            route B/R responses back to the issuing requester.
// Revision : 1.0
// ============================================================================
module blackparrot_fpga_host_cmd_arbiter
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64,
    parameter int tag_els_p    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [num_req_p-1:0]                  req_v_i,
    input  logic [num_req_p-1:0]                  req_w_i,
    input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
    input  logic [num_req_p*data_width_p-1:0]     req_data_i,
    input  logic [num_req_p*(data_width_p/8)-1:0] req_wmask_i,
    input  logic [num_req_p*3-1:0]                req_size_i,
    output logic [num_req_p-1:0]                  req_ready_and_o,
    output logic [num_req_p-1:0]                  resp_v_o,
    output logic                                  resp_w_o,
    output logic [data_width_p-1:0]               resp_data_o,
    input  logic [num_req_p-1:0]                  resp_yumi_i,
    output logic                                  cmd_v_o,
    output logic                                  cmd_w_o,
    output logic [addr_width_p-1:0]               cmd_addr_o,
    output logic [data_width_p-1:0]               cmd_data_o,
    output logic [data_width_p/8-1:0]             cmd_wmask_o,
    output logic [2:0]                            cmd_size_o,
    input  logic                                  cmd_ready_and_i,
    input  logic                                  br_resp_v_i,
    input  logic                                  br_resp_w_i,
    input  logic [data_width_p-1:0]               br_resp_data_i,
    output logic                                  br_resp_yumi_o,
    output logic [$clog2(tag_els_p+1)-1:0]        wr_outstanding_o,
    output logic [$clog2(tag_els_p+1)-1:0]        rd_outstanding_o,
    output logic                                  idle_o
);

    localparam int c_tag_width  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int c_cnt_width  = $clog2(tag_els_p + 1);
    localparam int c_mask_width = data_width_p / 8;

    host_cmd_s              w_cmd [num_req_p];
    host_cmd_s              w_win;
    logic [num_req_p-1:0]   w_elig;
    logic [num_req_p-1:0]   w_grants;
    logic                   w_grant_v;
    logic [c_tag_width-1:0] w_grant_idx;
    logic                   w_hs;
    logic                   w_wr_push;
    logic                   w_rd_push;
    logic                   w_wr_ready;
    logic                   w_rd_ready;
    logic                   w_wr_v;
    logic                   w_rd_v;
    logic [c_tag_width-1:0] w_wr_head;
    logic [c_tag_width-1:0] w_rd_head;
    logic [c_tag_width-1:0] w_head;
    logic                   w_sel_v;
    logic                   w_wr_pop;
    logic                   w_rd_pop;
    logic [c_cnt_width-1:0] r_wr_cnt;
    logic [c_cnt_width-1:0] r_rd_cnt;

    // A requester only competes if the tag FIFO of its command type has room.
    generate
        for (genvar i = 0; i < num_req_p; i++) begin : g_req
            assign w_cmd[i] = '{
                w:     req_w_i[i],
                addr:  c_host_addr_width'(req_addr_i[i*addr_width_p +: addr_width_p]),
                data:  c_host_data_width'(req_data_i[i*data_width_p +: data_width_p]),
                wmask: c_host_mask_width'(req_wmask_i[i*c_mask_width +: c_mask_width]),
                size:  req_size_i[i*3 +: 3]
            };
            assign w_elig[i]   = ~reset & req_v_i[i] & (req_w_i[i] ? w_wr_ready : w_rd_ready);
            assign resp_v_o[i] = ~reset & br_resp_v_i & w_sel_v
                               & (w_head == c_tag_width'(i));
        end
    endgenerate

    bsg_arb_round_robin #(
        .width_p (num_req_p)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .reqs_i   (w_elig),
        .yumi_i   (w_hs),
        .v_o      (w_grant_v),
        .grants_o (w_grants),
        .tag_o    (w_grant_idx)
    );

    assign w_win           = w_cmd[w_grant_idx];
    assign cmd_v_o         = w_grant_v;
    assign cmd_w_o         = w_win.w;
    assign cmd_addr_o      = w_win.addr[addr_width_p-1:0];
    assign cmd_data_o      = w_win.data[data_width_p-1:0];
    assign cmd_wmask_o     = w_win.wmask[c_mask_width-1:0];
    assign cmd_size_o      = w_win.size;
    assign req_ready_and_o = w_grants & {num_req_p{cmd_ready_and_i}};

    assign w_hs      = w_grant_v & cmd_ready_and_i;
    assign w_wr_push = w_hs & w_win.w;
    assign w_rd_push = w_hs & ~w_win.w;

    bsg_fifo_1r1w_small #(
        .width_p (c_tag_width),
        .els_p   (tag_els_p)
    ) u_wr_tags (
        .clk     (clk),
        .reset   (reset),
        .v_i     (w_wr_push),
        .ready_o (w_wr_ready),
        .data_i  (w_grant_idx),
        .v_o     (w_wr_v),
        .data_o  (w_wr_head),
        .yumi_i  (w_wr_pop)
    );

    bsg_fifo_1r1w_small #(
        .width_p (c_tag_width),
        .els_p   (tag_els_p)
    ) u_rd_tags (
        .clk     (clk),
        .reset   (reset),
        .v_i     (w_rd_push),
        .ready_o (w_rd_ready),
        .data_i  (w_grant_idx),
        .v_o     (w_rd_v),
        .data_o  (w_rd_head),
        .yumi_i  (w_rd_pop)
    );

    // With no matching tag the response is spurious and is simply swallowed.
    assign w_sel_v        = br_resp_w_i ? w_wr_v : w_rd_v;
    assign w_head         = br_resp_w_i ? w_wr_head : w_rd_head;
    assign br_resp_yumi_o = br_resp_v_i & (w_sel_v ? resp_yumi_i[w_head] : 1'b1);
    assign w_wr_pop       = br_resp_yumi_o & br_resp_w_i & w_wr_v;
    assign w_rd_pop       = br_resp_yumi_o & ~br_resp_w_i & w_rd_v;
    assign resp_w_o       = br_resp_w_i;
    assign resp_data_o    = br_resp_data_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_wr_cnt <= r_wr_cnt + c_cnt_width'(w_wr_push) - c_cnt_width'(w_wr_pop);
            r_rd_cnt <= r_rd_cnt + c_cnt_width'(w_rd_push) - c_cnt_width'(w_rd_pop);
        end
    end

    assign wr_outstanding_o = r_wr_cnt;
    assign rd_outstanding_o = r_rd_cnt;
    assign idle_o           = (r_wr_cnt == '0) && (r_rd_cnt == '0);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!br_resp_v_i || w_sel_v)
                else $warning("spurious bridge response dropped (w=%0b)", br_resp_w_i);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_blackparrot_fpga_host_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_blackparrot_fpga_host_cmd_arbiter
// Brief    : Randomized and directed bench against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_blackparrot_fpga_host_cmd_arbiter;

    localparam int N     = 2;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int MW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_v_i, req_w_i;
    logic [N*AW-1:0]  req_addr_i;
    logic [N*DW-1:0]  req_data_i;
    logic [N*MW-1:0]  req_wmask_i;
    logic [N*3-1:0]   req_size_i;
    logic [N-1:0]     req_ready_and_o, resp_v_o, resp_yumi_i;
    logic             resp_w_o;
    logic [DW-1:0]    resp_data_o;
    logic             cmd_v_o, cmd_w_o, cmd_ready_and_i;
    logic [AW-1:0]    cmd_addr_o;
    logic [DW-1:0]    cmd_data_o;
    logic [MW-1:0]    cmd_wmask_o;
    logic [2:0]       cmd_size_o;
    logic             br_resp_v_i, br_resp_w_i, br_resp_yumi_o;
    logic [DW-1:0]    br_resp_data_i;
    logic [CW-1:0]    wr_outstanding_o, rd_outstanding_o;
    logic             idle_o;

    blackparrot_fpga_host_cmd_arbiter #(
        .num_req_p    (N),
        .addr_width_p (AW),
        .data_width_p (DW),
        .tag_els_p    (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_v_i          (req_v_i),
        .req_w_i          (req_w_i),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .req_wmask_i      (req_wmask_i),
        .req_size_i       (req_size_i),
        .req_ready_and_o  (req_ready_and_o),
        .resp_v_o         (resp_v_o),
        .resp_w_o         (resp_w_o),
        .resp_data_o      (resp_data_o),
        .resp_yumi_i      (resp_yumi_i),
        .cmd_v_o          (cmd_v_o),
        .cmd_w_o          (cmd_w_o),
        .cmd_addr_o       (cmd_addr_o),
        .cmd_data_o       (cmd_data_o),
        .cmd_wmask_o      (cmd_wmask_o),
        .cmd_size_o       (cmd_size_o),
        .cmd_ready_and_i  (cmd_ready_and_i),
        .br_resp_v_i      (br_resp_v_i),
        .br_resp_w_i      (br_resp_w_i),
        .br_resp_data_i   (br_resp_data_i),
        .br_resp_yumi_o   (br_resp_yumi_o),
        .wr_outstanding_o (wr_outstanding_o),
        .rd_outstanding_o (rd_outstanding_o),
        .idle_o           (idle_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: issue-ordered requester ids per command type, plus the RR pointer.
    int       wq[$];
    int       rq[$];
    int       ptr;
    logic [N-1:0] acc;
    bit       rsp_taken;
    int       last_win;
    int       n_tests;
    int       n_fail;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance it.
    task automatic step();
        int win;
        int head;
        int j;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        @(negedge clk);
        win = -1;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (win < 0 && req_v_i[j] && (req_w_i[j] ? (wq.size() < DEPTH) : (rq.size() < DEPTH)))
                win = j;
        end
        check_value("cmd_v", 64'(cmd_v_o), 64'(win >= 0));
        if (win >= 0) begin
            check_value("cmd_w", 64'(cmd_w_o), 64'(req_w_i[win]));
            check_value("cmd_addr", cmd_addr_o, req_addr_i[win*AW +: AW]);
            check_value("cmd_data", cmd_data_o, req_data_i[win*DW +: DW]);
            check_value("cmd_wmask", 64'(cmd_wmask_o), 64'(req_wmask_i[win*MW +: MW]));
            check_value("cmd_size", 64'(cmd_size_o), 64'(req_size_i[win*3 +: 3]));
        end
        exp_rdy = '0;
        if (win >= 0 && cmd_ready_and_i) exp_rdy[win] = 1'b1;
        check_value("req_ready", 64'(req_ready_and_o), 64'(exp_rdy));

        head = -1;
        if (br_resp_w_i && wq.size() > 0) head = wq[0];
        if (!br_resp_w_i && rq.size() > 0) head = rq[0];
        exp_rv = '0;
        if (br_resp_v_i && head >= 0) exp_rv[head] = 1'b1;
        check_value("resp_v", 64'(resp_v_o), 64'(exp_rv));
        if (br_resp_v_i) begin
            check_value("br_yumi", 64'(br_resp_yumi_o),
                        64'((head >= 0) ? resp_yumi_i[head] : 1'b1));
            if (head >= 0) begin
                check_value("resp_w", 64'(resp_w_o), 64'(br_resp_w_i));
                check_value("resp_data", resp_data_o, br_resp_data_i);
            end
        end
        check_value("wr_out", 64'(wr_outstanding_o), 64'(wq.size()));
        check_value("rd_out", 64'(rd_outstanding_o), 64'(rq.size()));
        check_value("idle", 64'(idle_o), 64'(wq.size() == 0 && rq.size() == 0));

        acc       = '0;
        rsp_taken = 1'b0;
        last_win  = win;
        if (win >= 0 && cmd_ready_and_i) begin
            if (req_w_i[win]) wq.push_back(win);
            else              rq.push_back(win);
            ptr      = (win + 1) % N;
            acc[win] = 1'b1;
        end
        if (br_resp_v_i && (head < 0 || resp_yumi_i[head])) begin
            rsp_taken = 1'b1;
            if (head >= 0) begin
                if (br_resp_w_i) void'(wq.pop_front());
                else             void'(rq.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [63:0] addr);
        req_v_i[i]               = v;
        req_w_i[i]               = w;
        req_addr_i[i*AW +: AW]   = addr;
        req_data_i[i*DW +: DW]   = {$urandom, $urandom};
        req_wmask_i[i*MW +: MW]  = MW'($urandom);
        req_size_i[i*3 +: 3]     = 3'($urandom);
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_v_i[i])
                set_req(i, ($urandom_range(0, 9) < 6), 1'($urandom), {$urandom, $urandom});
        end
    endtask

    // Bridge responds in order within each type, picking a type at random.
    task automatic bridge_drive(input bit eager);
        if (rsp_taken) br_resp_v_i = 1'b0;
        if (!br_resp_v_i && (wq.size() + rq.size() > 0) && (eager || $urandom_range(0, 2) == 0)) begin
            br_resp_v_i = 1'b1;
            if (wq.size() == 0)      br_resp_w_i = 1'b0;
            else if (rq.size() == 0) br_resp_w_i = 1'b1;
            else                     br_resp_w_i = 1'($urandom);
            br_resp_data_i = {$urandom, $urandom};
        end
        if (!br_resp_v_i) resp_yumi_i = '0;
        else if (eager)   resp_yumi_i = '1;
        else              resp_yumi_i = N'($urandom_range(0, 3));
        rsp_taken = 1'b0;
    endtask

    task automatic drain();
        req_v_i         = '0;
        cmd_ready_and_i = 1'b1;
        for (int c = 0; c < 64 && (wq.size() + rq.size() > 0 || br_resp_v_i); c++) begin
            bridge_drive(1'b1);
            step();
            if (rsp_taken) br_resp_v_i = 1'b0;
        end
        check_value("drain_empty", 64'(wq.size() + rq.size()), 64'd0);
        br_resp_v_i = 1'b0;
        resp_yumi_i = '0;
        rsp_taken   = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        br_resp_v_i = 1'b0;
        resp_yumi_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_cmd_v", 64'(cmd_v_o), 64'd0);
        check_value("rst_ready", 64'(req_ready_and_o), 64'd0);
        check_value("rst_resp_v", 64'(resp_v_o), 64'd0);
        reset = 1'b0;
        wq.delete();
        rq.delete();
        ptr       = 0;
        acc       = '0;
        rsp_taken = 1'b0;
        #1;
        check_value("rst_wr_out", 64'(wr_outstanding_o), 64'd0);
        check_value("rst_rd_out", 64'(rd_outstanding_o), 64'd0);
        check_value("rst_idle", 64'(idle_o), 64'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        req_v_i = '0; req_w_i = '0; req_addr_i = '0; req_data_i = '0;
        req_wmask_i = '0; req_size_i = '0; resp_yumi_i = '0;
        cmd_ready_and_i = 1'b0; br_resp_v_i = 1'b0; br_resp_w_i = 1'b0; br_resp_data_i = '0;
        do_reset();

        // Single read from requester 1.
        cmd_ready_and_i = 1'b1;
        set_req(1, 1'b1, 1'b0, 64'h8000_0000);
        step();
        check_value("t1_win", 64'(last_win), 64'd1);
        req_v_i = '0;
        check_value("t1_rd_out", 64'(rd_outstanding_o), 64'd1);
        br_resp_v_i = 1'b1; br_resp_w_i = 1'b0; br_resp_data_i = 64'hDEAD_BEEF_CAFE_F00D;
        resp_yumi_i = 2'b10;
        #1;
        check_value("t1_resp_v", 64'(resp_v_o), 64'b10);
        check_value("t1_data", resp_data_o, 64'hDEAD_BEEF_CAFE_F00D);
        step();
        br_resp_v_i = 1'b0; resp_yumi_i = '0;
        check_value("t1_rd_out0", 64'(rd_outstanding_o), 64'd0);

        // Both requesters hold writes: grants alternate, acks route in order.
        set_req(0, 1'b1, 1'b1, 64'h100);
        set_req(1, 1'b1, 1'b1, 64'h200);
        for (int k = 0; k < 6; k++) begin
            bridge_drive(1'b1);
            step();
            check_value("t2_grant", 64'(last_win), 64'(k % 2));
        end
        drain();

        // Read tag FIFO fills; requester 0 stalls, a write still gets through.
        set_req(0, 1'b1, 1'b0, 64'h40);
        for (int k = 0; k < DEPTH; k++) step();
        set_req(1, 1'b1, 1'b1, 64'h300);
        #1;
        check_value("t3_stall", 64'(req_ready_and_o), 64'b10);
        step();
        req_v_i[1] = 1'b0;
        br_resp_v_i = 1'b1; br_resp_w_i = 1'b0; br_resp_data_i = 64'h1234; resp_yumi_i = 2'b01;
        #1;
        check_value("t3_full_pop", 64'(req_ready_and_o[0]), 64'd0);
        step();
        br_resp_v_i = 1'b0; resp_yumi_i = '0;
        #1;
        check_value("t3_unblock", 64'(req_ready_and_o[0]), 64'd1);
        step();
        drain();

        // Read answered before the older write.
        set_req(0, 1'b1, 1'b1, 64'h100);
        set_req(1, 1'b1, 1'b0, 64'h500);
        for (int k = 0; k < 4 && req_v_i != '0; k++) begin
            step();
            req_v_i = req_v_i & ~acc;
        end
        check_value("t4_issued", 64'(req_v_i), 64'd0);
        br_resp_v_i = 1'b1; br_resp_w_i = 1'b0; br_resp_data_i = 64'h55AA; resp_yumi_i = 2'b11;
        #1;
        check_value("t4_rd_route", 64'(resp_v_o), 64'b10);
        step();
        br_resp_w_i = 1'b1;
        #1;
        check_value("t4_wr_route", 64'(resp_v_o), 64'b01);
        check_value("t4_not_idle", 64'(idle_o), 64'd0);
        step();
        br_resp_v_i = 1'b0; resp_yumi_i = '0;
        check_value("t4_idle", 64'(idle_o), 64'd1);

        // Consumer back-pressure, then a spurious write ack.
        set_req(0, 1'b1, 1'b0, 64'h80);
        step();
        req_v_i = '0;
        br_resp_v_i = 1'b1; br_resp_w_i = 1'b0; br_resp_data_i = 64'h77; resp_yumi_i = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_value("t5_hold_yumi", 64'(br_resp_yumi_o), 64'd0);
            check_value("t5_hold_v", 64'(resp_v_o), 64'b01);
            step();
        end
        resp_yumi_i = 2'b01;
        step();
        br_resp_w_i = 1'b1; resp_yumi_i = '0;
        #1;
        check_value("t5_spur_yumi", 64'(br_resp_yumi_o), 64'd1);
        check_value("t5_spur_v", 64'(resp_v_o), 64'd0);
        step();
        br_resp_v_i = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_reqs();
            bridge_drive(1'b0);
            cmd_ready_and_i = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset with reads outstanding.
        cmd_ready_and_i = 1'b1;
        set_req(0, 1'b1, 1'b0, 64'h10);
        set_req(1, 1'b1, 1'b0, 64'h20);
        for (int k = 0; k < 4 && req_v_i != '0; k++) begin
            step();
            req_v_i = req_v_i & ~acc;
        end
        check_value("t6_rd_out", 64'(rd_outstanding_o), 64'd2);
        set_req(0, 1'b1, 1'b0, 64'h30);
        set_req(1, 1'b1, 1'b0, 64'h40);
        do_reset();
        step();
        check_value("t6_first_grant", 64'(last_win), 64'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
